// File: rtl/csr_pkg.sv
// Shared definitions for the CSR/trap sequencer.
//  - request op encodings
//  - machine-mode CSR addresses handled by the sequencer
//  - mcause values raised by the sequencer
//  - mstatus bit positions touched by MRET
//  - FSM state and request-kind enums
//  - small decode helpers
package csr_pkg;

  localparam logic [2:0] OP_CSRRW = 3'b001;
  localparam logic [2:0] OP_CSRRS = 3'b010;
  localparam logic [2:0] OP_CSRRC = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned CAUSE_ILLEGAL = 2;
  localparam int unsigned CAUSE_ECALL   = 11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_TRAP,
    ST_RET_EPC,
    ST_RET_ST_RD,
    ST_RET_ST_WR,
    ST_RESP
  } state_e;

  // What the accepted request turned into; selects the response format.
  typedef enum logic [1:0] {
    KIND_CSR,
    KIND_TRAP,
    KIND_MRET
  } kind_e;

  function automatic logic is_csr_op(input logic [2:0] op);
    return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
  endfunction

  function automatic logic is_legal_csr(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write data path for CSRRW/CSRRS/CSRRC (combinational).
// Ports:
//  op        in   3     request op (only CSR ops are meaningful)
//  old       in   XLEN  CSR value read in the RD state
//  src       in   XLEN  rs1 value
//  wdata     out  XLEN  value to write back
//  do_write  out  1     0 when a set/clear with src==0 must leave the CSR untouched
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] wdata,
  output logic            do_write
);

  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_bit
      assign wdata[gi] = (op == OP_CSRRS) ? (old[gi] | src[gi]) :
                         (op == OP_CSRRC) ? (old[gi] & ~src[gi]) :
                                            src[gi];
    end
  endgenerate

  // CSRRS/CSRRC with rs1==0 is a pure read: no write side effects.
  assign do_write = (op == OP_CSRRW) || (src != '0);

endmodule

// File: rtl/csr_trap_seq.sv
// Sequencer between the execute stage and the CSR register file.
// Runs CSR read-modify-write ops, raises ECALL/illegal traps and performs
// MRET (mepc fetch plus mstatus restore), then returns rd data and an
// optional redirect PC to the core.
// Ports:
//  clk, rst                         clock, synchronous active-high reset
//  req_valid/req_ready              request handshake (ready only in IDLE)
//  req_op/req_csr/req_src/req_pc    request fields, latched on accept
//  resp_valid/resp_ready            response handshake (valid held until ready)
//  resp_rd_data                     old CSR value for CSR ops, else 0
//  resp_redirect/resp_next_pc       redirect flag and target (mtvec or mepc)
//  csr_addr/csr_wen/csr_wdata       CSR file write/read port
//  csr_rdata                        CSR file combinational read data
//  intr/intr_NO/intr_epc            one-cycle trap strobe with cause and PC
//  intr_mtvec                       current mtvec from the CSR file
module csr_trap_seq
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_csr,
  input  logic [XLEN-1:0] req_src,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rd_data,
  output logic            resp_redirect,
  output logic [XLEN-1:0] resp_next_pc,
  output logic [XLEN-1:0] csr_addr,
  output logic            csr_wen,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            intr,
  output logic [XLEN-1:0] intr_NO,
  output logic [XLEN-1:0] intr_epc,
  input  logic [XLEN-1:0] intr_mtvec
);

  state_e          state_reg, state_next;
  kind_e           kind_reg, kind_next;
  logic [2:0]      op_reg, op_next;
  logic [XLEN-1:0] src_reg, src_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] cause_reg, cause_next;
  logic [XLEN-1:0] old_reg, old_next;
  logic [XLEN-1:0] next_pc_reg, next_pc_next;
  logic [XLEN-1:0] addr_reg, addr_next;

  logic [XLEN-1:0] alu_wdata;
  logic            alu_do_write;
  logic [XLEN-1:0] mret_wdata;

  csr_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op      (op_reg),
    .old     (old_reg),
    .src     (src_reg),
    .wdata   (alu_wdata),
    .do_write(alu_do_write)
  );

  // MRET mstatus update: MIE <= MPIE, MPIE <= 1, MPP <= U, rest unchanged.
  always_comb begin
    mret_wdata                                = old_reg;
    mret_wdata[MSTATUS_MIE]                   = old_reg[MSTATUS_MPIE];
    mret_wdata[MSTATUS_MPIE]                  = 1'b1;
    mret_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

  // The address is a register so it stays at its last value in states that
  // do not access the CSR file.
  assign csr_addr = addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      kind_reg    <= KIND_CSR;
      op_reg      <= '0;
      src_reg     <= '0;
      pc_reg      <= '0;
      cause_reg   <= '0;
      old_reg     <= '0;
      next_pc_reg <= '0;
      addr_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      kind_reg    <= kind_next;
      op_reg      <= op_next;
      src_reg     <= src_next;
      pc_reg      <= pc_next;
      cause_reg   <= cause_next;
      old_reg     <= old_next;
      next_pc_reg <= next_pc_next;
      addr_reg    <= addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    kind_next     = kind_reg;
    op_next       = op_reg;
    src_next      = src_reg;
    pc_next       = pc_reg;
    cause_next    = cause_reg;
    old_next      = old_reg;
    next_pc_next  = next_pc_reg;
    addr_next     = addr_reg;

    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rd_data  = '0;
    resp_redirect = 1'b0;
    resp_next_pc  = '0;
    csr_wen       = 1'b0;
    csr_wdata     = '0;
    intr          = 1'b0;
    intr_NO       = '0;
    intr_epc      = '0;

    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_next  = req_op;
          src_next = req_src;
          pc_next  = req_pc;
          if (is_csr_op(req_op) && is_legal_csr(req_csr)) begin
            kind_next  = KIND_CSR;
            addr_next  = {{(XLEN-12){1'b0}}, req_csr};
            state_next = ST_RD;
          end else if (req_op == OP_MRET) begin
            kind_next  = KIND_MRET;
            addr_next  = {{(XLEN-12){1'b0}}, CSR_MEPC};
            state_next = ST_RET_EPC;
          end else begin
            // ECALL, unknown op, or CSR op on an unimplemented address.
            kind_next  = KIND_TRAP;
            cause_next = (req_op == OP_ECALL) ? XLEN'(CAUSE_ECALL)
                                              : XLEN'(CAUSE_ILLEGAL);
            state_next = ST_TRAP;
          end
        end
      end

      ST_RD: begin
        old_next   = csr_rdata;
        state_next = ST_WR;
      end

      ST_WR: begin
        // Strobes are masked by rst so an abort in this cycle has no effect.
        if (alu_do_write && !rst) begin
          csr_wen   = 1'b1;
          csr_wdata = alu_wdata;
        end
        state_next = ST_RESP;
      end

      ST_TRAP: begin
        if (!rst) begin
          intr     = 1'b1;
          intr_NO  = cause_reg;
          intr_epc = pc_reg;
        end
        next_pc_next = intr_mtvec;
        state_next   = ST_RESP;
      end

      ST_RET_EPC: begin
        next_pc_next = csr_rdata;
        addr_next    = {{(XLEN-12){1'b0}}, CSR_MSTATUS};
        state_next   = ST_RET_ST_RD;
      end

      ST_RET_ST_RD: begin
        old_next   = csr_rdata;
        state_next = ST_RET_ST_WR;
      end

      ST_RET_ST_WR: begin
        if (!rst) begin
          csr_wen   = 1'b1;
          csr_wdata = mret_wdata;
        end
        state_next = ST_RESP;
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        if (kind_reg == KIND_CSR) begin
          resp_rd_data = old_reg;
        end else begin
          resp_redirect = 1'b1;
          resp_next_pc  = next_pc_reg;
        end
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
module tb_csr_trap_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = '0;
  logic [11:0]     req_csr = '0;
  logic [XLEN-1:0] req_src = '0;
  logic [XLEN-1:0] req_pc = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_rd_data;
  logic            resp_redirect;
  logic [XLEN-1:0] resp_next_pc;
  logic [XLEN-1:0] csr_addr;
  logic            csr_wen;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            intr;
  logic [XLEN-1:0] intr_NO;
  logic [XLEN-1:0] intr_epc;
  logic [XLEN-1:0] intr_mtvec;

  always #5 clk = ~clk;

  csr_trap_seq #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_csr      (req_csr),
    .req_src      (req_src),
    .req_pc       (req_pc),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd_data (resp_rd_data),
    .resp_redirect(resp_redirect),
    .resp_next_pc (resp_next_pc),
    .csr_addr     (csr_addr),
    .csr_wen      (csr_wen),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .intr         (intr),
    .intr_NO      (intr_NO),
    .intr_epc     (intr_epc),
    .intr_mtvec   (intr_mtvec)
  );

  // ---------------- CSR register file stand-in ----------------
  // index 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
  logic [31:0] mem [4];
  logic        poke_en = 1'b0;
  logic [1:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  function automatic int idx_of(input logic [31:0] a);
    case (a)
      32'h300: return 0;
      32'h305: return 1;
      32'h341: return 2;
      32'h342: return 3;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (csr_wen && idx_of(csr_addr) >= 0) begin
      mem[idx_of(csr_addr)] <= csr_wdata;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end
  end

  always_comb begin
    int k;
    k = idx_of(csr_addr);
    csr_rdata = (k >= 0) ? mem[k[1:0]] : '0;
  end

  assign intr_mtvec = mem[1];

  // ---------------- strobe monitor ----------------
  int          wen_cnt = 0;
  int          intr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] wen_addr_last = '0;
  logic [31:0] wen_data_last = '0;
  logic [31:0] intr_no_last = '0;
  logic [31:0] intr_epc_last = '0;

  always @(negedge clk) begin
    if (csr_wen) begin
      wen_cnt       <= wen_cnt + 1;
      wen_addr_last <= csr_addr;
      wen_data_last <= csr_wdata;
    end
    if (intr) begin
      intr_cnt      <= intr_cnt + 1;
      intr_no_last  <= intr_NO;
      intr_epc_last <= intr_epc;
    end
    if (csr_wen && intr) both_cnt <= both_cnt + 1;
  end

  // ---------------- counters and observations ----------------
  int checks = 0;
  int failures = 0;

  int          obs_lat;
  logic [31:0] obs_rd;
  logic        obs_redir;
  logic [31:0] obs_npc;
  logic        obs_stable;
  logic        obs_ready_pre;
  logic        obs_ready_post;
  logic        obs_valid_post;
  int          obs_wen_n;
  int          obs_intr_n;
  int          obs_both_n;

  // Reference model state (independent of the stand-in's storage).
  logic [31:0] model_csr [4];
  int          exp_lat;
  logic [31:0] exp_rd;
  logic        exp_redir;
  logic [31:0] exp_npc;
  int          exp_wen_n;
  logic [31:0] exp_wen_addr;
  logic [31:0] exp_wen_data;
  int          exp_intr_n;
  logic [31:0] exp_no;
  logic [31:0] exp_epc;

  task automatic poke(input int i, input logic [31:0] v);
    poke_en  = 1'b1;
    poke_idx = 2'(i);
    poke_val = v;
    @(posedge clk); #1;
    poke_en  = 1'b0;
  endtask

  // Drives one request, waits for the response, stalls resp_ready for
  // 'delay' cycles, completes the handshake and records what was observed.
  task automatic run_txn(input logic [2:0] op, input logic [11:0] csr,
                         input logic [31:0] src, input logic [31:0] pc,
                         input int delay);
    int wen0, intr0, both0;
    wen0  = wen_cnt;
    intr0 = intr_cnt;
    both0 = both_cnt;
    obs_ready_pre = req_ready;
    req_valid = 1'b1;
    req_op    = op;
    req_csr   = csr;
    req_src   = src;
    req_pc    = pc;
    @(posedge clk); #1;
    // Garbage while busy: must be neither latched nor queued.
    req_valid = 1'($urandom);
    req_op    = 3'($urandom);
    req_csr   = 12'($urandom);
    req_src   = $urandom;
    req_pc    = $urandom;
    obs_lat = 1;
    while (!resp_valid && obs_lat < 20) begin
      @(posedge clk); #1;
      obs_lat++;
    end
    obs_rd     = resp_rd_data;
    obs_redir  = resp_redirect;
    obs_npc    = resp_next_pc;
    obs_stable = 1'b1;
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_rd_data !== obs_rd || resp_redirect !== obs_redir ||
          resp_next_pc !== obs_npc)
        obs_stable = 1'b0;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    obs_ready_post = req_ready;
    obs_valid_post = resp_valid;
    obs_wen_n  = wen_cnt - wen0;
    obs_intr_n = intr_cnt - intr0;
    obs_both_n = both_cnt - both0;
    $display("txn op=%0d csr=%03h src=%08h pc=%08h lat=%0d rd=%08h redir=%0b npc=%08h wen=%0d intr=%0d",
             op, csr, src, pc, obs_lat, obs_rd, obs_redir, obs_npc, obs_wen_n, obs_intr_n);
  endtask

  // Expected outcome of one request, derived from the architectural rules.
  task automatic model_txn(input logic [2:0] op, input logic [11:0] csr,
                           input logic [31:0] src, input logic [31:0] pc);
    int          k;
    logic [31:0] old;
    logic [31:0] m;
    k = idx_of({20'h0, csr});
    exp_rd = '0; exp_redir = 1'b0; exp_npc = '0;
    exp_wen_n = 0; exp_wen_addr = '0; exp_wen_data = '0;
    exp_intr_n = 0; exp_no = '0; exp_epc = '0;
    if (op >= 3'd1 && op <= 3'd3 && k >= 0) begin
      old     = model_csr[k];
      exp_lat = 3;
      exp_rd  = old;
      exp_wen_addr = {20'h0, csr};
      if (op == 3'd1) exp_wen_data = src;
      else if (op == 3'd2) exp_wen_data = old | src;
      else exp_wen_data = old & ~src;
      if (op == 3'd1 || src != 0) begin
        exp_wen_n    = 1;
        model_csr[k] = exp_wen_data;
      end
    end else if (op == 3'd5) begin
      m = model_csr[0];
      exp_lat      = 4;
      exp_redir    = 1'b1;
      exp_npc      = model_csr[2];
      exp_wen_n    = 1;
      exp_wen_addr = 32'h300;
      exp_wen_data = (m & ~32'h0000_1888) | 32'h80 | (((m >> 7) & 32'h1) << 3);
      model_csr[0] = exp_wen_data;
    end else begin
      exp_lat    = 2;
      exp_redir  = 1'b1;
      exp_npc    = model_csr[1];
      exp_intr_n = 1;
      exp_no     = (op == 3'd4) ? 32'd11 : 32'd2;
      exp_epc    = pc;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'($urandom);
    req_op = 3'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got=%0b exp=1", req_ready);
    end
    checks++;
    if ({resp_valid, resp_redirect, csr_wen, intr} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%04b exp=0000", {resp_valid, resp_redirect, csr_wen, intr});
    end
    checks++;
    if ({resp_rd_data, resp_next_pc, csr_addr, csr_wdata, intr_NO, intr_epc} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0",
               {resp_rd_data, resp_next_pc, csr_addr, csr_wdata, intr_NO, intr_epc});
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_csrrw();
    run_txn(3'b001, 12'h305, 32'h8000_0100, 32'h0, 0);
    checks++;
    if (obs_ready_pre !== 1'b1) begin failures++; $display("FAIL csrrw_ready got=%0b exp=1", obs_ready_pre); end
    checks++;
    if (obs_lat !== 3) begin failures++; $display("FAIL csrrw_latency got=%0d exp=3", obs_lat); end
    checks++;
    if (obs_wen_n !== 1 || wen_addr_last !== 32'h305 || wen_data_last !== 32'h8000_0100) begin
      failures++;
      $display("FAIL csrrw_write got=%0d@%h=%h exp=1@305=80000100", obs_wen_n, wen_addr_last, wen_data_last);
    end
    checks++;
    if (obs_rd !== 32'h0 || obs_redir !== 1'b0) begin
      failures++;
      $display("FAIL csrrw_resp got=rd %h redir %0b exp=rd 0 redir 0", obs_rd, obs_redir);
    end
    checks++;
    if (obs_ready_post !== 1'b1 || obs_valid_post !== 1'b0) begin
      failures++;
      $display("FAIL csrrw_idle got=ready %0b valid %0b exp=1 0", obs_ready_post, obs_valid_post);
    end
  endtask

  task automatic test_ecall();
    poke(1, 32'h8000_0100);
    run_txn(3'b100, 12'h000, 32'h0, 32'h8000_0040, 1);
    checks++;
    if (obs_intr_n !== 1 || intr_no_last !== 32'd11 || intr_epc_last !== 32'h8000_0040) begin
      failures++;
      $display("FAIL ecall_intr got=%0d no=%0d epc=%h exp=1 no=11 epc=80000040",
               obs_intr_n, intr_no_last, intr_epc_last);
    end
    checks++;
    if (obs_wen_n !== 0) begin failures++; $display("FAIL ecall_no_wen got=%0d exp=0", obs_wen_n); end
    checks++;
    if (obs_redir !== 1'b1 || obs_npc !== 32'h8000_0100 || obs_rd !== 32'h0) begin
      failures++;
      $display("FAIL ecall_resp got=redir %0b npc %h rd %h exp=1 80000100 0", obs_redir, obs_npc, obs_rd);
    end
    checks++;
    if (obs_lat !== 2) begin failures++; $display("FAIL ecall_latency got=%0d exp=2", obs_lat); end
  endtask

  task automatic test_csrrs_rc();
    poke(0, 32'h0000_1880);
    run_txn(3'b010, 12'h300, 32'h8, 32'h0, 0);
    checks++;
    if (obs_wen_n !== 1 || wen_data_last !== 32'h0000_1888 || obs_rd !== 32'h0000_1880) begin
      failures++;
      $display("FAIL csrrs_set got=wen %0d data %h rd %h exp=1 00001888 00001880",
               obs_wen_n, wen_data_last, obs_rd);
    end
    run_txn(3'b011, 12'h300, 32'h0, 32'h0, 2);
    checks++;
    if (obs_wen_n !== 0 || obs_rd !== 32'h0000_1888) begin
      failures++;
      $display("FAIL csrrc_zero got=wen %0d rd %h exp=0 00001888", obs_wen_n, obs_rd);
    end
  endtask

  task automatic test_mret();
    poke(0, 32'h0000_1880);
    poke(2, 32'h8000_0044);
    run_txn(3'b101, 12'h302, 32'h0, 32'h0, 0);
    checks++;
    if (obs_wen_n !== 1 || wen_addr_last !== 32'h300 || wen_data_last !== 32'h0000_0088) begin
      failures++;
      $display("FAIL mret_mstatus got=%0d@%h=%h exp=1@300=00000088", obs_wen_n, wen_addr_last, wen_data_last);
    end
    checks++;
    if (obs_redir !== 1'b1 || obs_npc !== 32'h8000_0044 || obs_rd !== 32'h0) begin
      failures++;
      $display("FAIL mret_resp got=redir %0b npc %h rd %h exp=1 80000044 0", obs_redir, obs_npc, obs_rd);
    end
    checks++;
    if (obs_lat !== 4 || obs_intr_n !== 0) begin
      failures++;
      $display("FAIL mret_timing got=lat %0d intr %0d exp=4 0", obs_lat, obs_intr_n);
    end
  endtask

  task automatic test_illegal();
    run_txn(3'b001, 12'h123, 32'hDEAD_BEEF, 32'h8000_0100, 5);
    checks++;
    if (obs_intr_n !== 1 || intr_no_last !== 32'd2 || obs_wen_n !== 0) begin
      failures++;
      $display("FAIL illegal_csr got=intr %0d no %0d wen %0d exp=1 2 0", obs_intr_n, intr_no_last, obs_wen_n);
    end
    checks++;
    if (obs_stable !== 1'b1) begin failures++; $display("FAIL resp_hold got=%0b exp=1", obs_stable); end
    run_txn(3'b111, 12'h300, 32'h1, 32'h8000_0200, 0);
    checks++;
    if (obs_intr_n !== 1 || intr_no_last !== 32'd2 || intr_epc_last !== 32'h8000_0200 || obs_wen_n !== 0) begin
      failures++;
      $display("FAIL illegal_op got=intr %0d no %0d epc %h wen %0d exp=1 2 80000200 0",
               obs_intr_n, intr_no_last, intr_epc_last, obs_wen_n);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [11:0] csr;
    logic [31:0] src;
    logic [31:0] pc;
    int          r;
    logic [11:0] legal [4];
    legal[0] = 12'h300; legal[1] = 12'h305; legal[2] = 12'h341; legal[3] = 12'h342;
    for (int i = 0; i < 4; i++) begin
      model_csr[i] = $urandom;
      poke(i, model_csr[i]);
    end
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) op = 3'($urandom_range(1, 3));
      else if (r == 6) op = 3'd4;
      else if (r == 7) op = 3'd5;
      else op = 3'($urandom);
      csr = ($urandom_range(0, 4) != 0) ? legal[$urandom_range(0, 3)] : 12'($urandom);
      src = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      model_txn(op, csr, src, pc);
      run_txn(op, csr, src, pc, $urandom_range(0, 3));
      checks++;
      if (obs_lat !== exp_lat || obs_ready_pre !== 1'b1 || obs_ready_post !== 1'b1) begin
        failures++;
        $display("FAIL rand_timing t=%0d got=lat %0d rdy %0b/%0b exp=lat %0d rdy 1/1",
                 t, obs_lat, obs_ready_pre, obs_ready_post, exp_lat);
      end
      checks++;
      if (obs_rd !== exp_rd || obs_redir !== exp_redir || obs_npc !== exp_npc || obs_stable !== 1'b1) begin
        failures++;
        $display("FAIL rand_resp t=%0d got=%h/%0b/%h stable %0b exp=%h/%0b/%h stable 1",
                 t, obs_rd, obs_redir, obs_npc, obs_stable, exp_rd, exp_redir, exp_npc);
      end
      checks++;
      if (obs_wen_n !== exp_wen_n || obs_intr_n !== exp_intr_n || obs_both_n !== 0) begin
        failures++;
        $display("FAIL rand_strobes t=%0d got=wen %0d intr %0d both %0d exp=wen %0d intr %0d both 0",
                 t, obs_wen_n, obs_intr_n, obs_both_n, exp_wen_n, exp_intr_n);
      end
      if (exp_wen_n == 1) begin
        checks++;
        if (wen_addr_last !== exp_wen_addr || wen_data_last !== exp_wen_data) begin
          failures++;
          $display("FAIL rand_wdata t=%0d got=%h=%h exp=%h=%h",
                   t, wen_addr_last, wen_data_last, exp_wen_addr, exp_wen_data);
        end
      end
      if (exp_intr_n == 1) begin
        checks++;
        if (intr_no_last !== exp_no || intr_epc_last !== exp_epc) begin
          failures++;
          $display("FAIL rand_trap t=%0d got=no %0d epc %h exp=no %0d epc %h",
                   t, intr_no_last, intr_epc_last, exp_no, exp_epc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int wen0, intr0;
    // Abort a CSRRW while in WR.
    wen0 = wen_cnt;
    req_valid = 1'b1; req_op = 3'b001; req_csr = 12'h305; req_src = $urandom | 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (csr_wen !== 1'b0) begin failures++; $display("FAIL rst_in_wr_wen got=%0b exp=0", csr_wen); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || {resp_valid, csr_wen, intr} !== 3'b0 || csr_addr !== '0 || resp_rd_data !== '0) begin
      failures++;
      $display("FAIL rst_wr_after got=ready %0b strobes %03b addr %h exp=1 000 0",
               req_ready, {resp_valid, csr_wen, intr}, csr_addr);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wen_cnt !== wen0) begin failures++; $display("FAIL rst_wr_no_wen got=%0d exp=0", wen_cnt - wen0); end

    // Abort an ECALL while in TRAP.
    intr0 = intr_cnt;
    req_valid = 1'b1; req_op = 3'b100; req_pc = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (intr !== 1'b0) begin failures++; $display("FAIL rst_in_trap_intr got=%0b exp=0", intr); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || {resp_valid, resp_redirect, intr} !== 3'b0 || intr_NO !== '0 || resp_next_pc !== '0) begin
      failures++;
      $display("FAIL rst_trap_after got=ready %0b strobes %03b no %0d npc %h exp=1 000 0 0",
               req_ready, {resp_valid, resp_redirect, intr}, intr_NO, resp_next_pc);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (intr_cnt !== intr0) begin failures++; $display("FAIL rst_trap_no_intr got=%0d exp=0", intr_cnt - intr0); end
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_ecall();
    test_csrrs_rc();
    test_mret();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
